// File: rtl/hazard_pkg.sv
// Shared types, default latencies and index-width helper for the ID-stage hazard scoreboard.
// Pure declarations; no logic, no latency, no backpressure.
package hazard_pkg;

    typedef enum logic [2:0] {
        OP_ALU     = 3'd0,
        OP_LOAD    = 3'd1,
        OP_MUL     = 3'd2,
        OP_DIV     = 3'd3,
        OP_HILO_RD = 3'd4
    } op_kind_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_DATA  = 2'd1,
        CAUSE_EARLY = 2'd2,
        CAUSE_MDU   = 2'd3
    } stall_cause_t;

    localparam int DEF_NREG     = 32;
    localparam int DEF_CNT_W    = 4;
    localparam int DEF_LAT_ALU  = 1;
    localparam int DEF_LAT_LOAD = 2;
    localparam int DEF_LAT_MUL  = 5;
    localparam int DEF_LAT_DIV  = 10;
    localparam int DEF_PERF_W   = 32;

    // Index width for n entries, never less than 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// HI/LO unit occupancy countdown: loads on start when idle, then counts down to zero.
// Busy is registered state (visible the cycle after start); start while busy is ignored.
module mdu_busy_timer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_lat,
    output logic             o_busy
);

    logic [CNT_W-1:0] r_timer;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_timer <= '0;
        end else if (i_start && (r_timer == '0)) begin
            r_timer <= i_lat;
        end else if (r_timer != '0) begin
            r_timer <= r_timer - CNT_W'(1);
        end
    end

    assign o_busy = (r_timer != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register pending-write countdowns plus MDU busy timer drive a stall.
// Stall is combinational from state and ID inputs; a stalled instruction is held in ID and re-checked each cycle.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG     = DEF_NREG,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LAT_ALU  = DEF_LAT_ALU,
    parameter int LAT_LOAD = DEF_LAT_LOAD,
    parameter int LAT_MUL  = DEF_LAT_MUL,
    parameter int LAT_DIV  = DEF_LAT_DIV,
    parameter int PERF_W   = DEF_PERF_W
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_id_valid,
    input  logic                     i_id_kill,
    input  logic [clog2(NREG)-1:0]   i_id_rs,
    input  logic [clog2(NREG)-1:0]   i_id_rt,
    input  logic                     i_id_use_rs,
    input  logic                     i_id_use_rt,
    input  logic                     i_id_early,
    input  logic                     i_id_wr,
    input  logic [clog2(NREG)-1:0]   i_id_rd,
    input  op_kind_t                 i_id_kind,
    output logic                     o_stall,
    output stall_cause_t             o_stall_cause,
    output logic                     o_mdu_busy,
    output logic [PERF_W-1:0]        o_stall_count
);

    localparam int IW = clog2(NREG);

    generate
        if ((LAT_DIV >= (1 << CNT_W)) || (LAT_MUL >= (1 << CNT_W)) ||
            (LAT_LOAD >= (1 << CNT_W)) || (LAT_ALU >= (1 << CNT_W))) begin : g_bad_lat
            $error("hazard_scoreboard: latency does not fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] L_ALU  = CNT_W'(LAT_ALU);
    localparam logic [CNT_W-1:0] L_LOAD = CNT_W'(LAT_LOAD);
    localparam logic [CNT_W-1:0] L_MUL  = CNT_W'(LAT_MUL);
    localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(LAT_DIV);

    logic [CNT_W-1:0]  r_cnt [NREG];
    logic [CNT_W-1:0]  w_dec [NREG];
    logic [PERF_W-1:0] r_stall_cnt;

    logic              w_active;
    logic              w_fire;
    logic [CNT_W-1:0]  w_thr;
    logic              w_rs_hz;
    logic              w_rt_hz;
    logic              w_data_stall;
    logic              w_mdu_kind;
    logic              w_mdu_stall;
    logic              w_mdu_busy;
    logic              w_mdu_start;
    logic [CNT_W-1:0]  w_mdu_lat;
    logic              w_wr_en;
    logic [CNT_W-1:0]  w_issue_lat;
    logic [CNT_W-1:0]  w_load_val;
    stall_cause_t      w_cause;

    assign w_active = i_id_valid && !i_id_kill;

    // Branch/JR consumes in ID, so it needs the value one cycle sooner than an EX consumer.
    assign w_thr   = i_id_early ? '0 : CNT_W'(1);
    assign w_rs_hz = i_id_use_rs && (i_id_rs != '0) && (r_cnt[i_id_rs] > w_thr);
    assign w_rt_hz = i_id_use_rt && (i_id_rt != '0) && (r_cnt[i_id_rt] > w_thr);
    assign w_data_stall = w_rs_hz || w_rt_hz;

    assign w_mdu_kind  = i_id_kind inside {OP_MUL, OP_DIV, OP_HILO_RD};
    assign w_mdu_stall = w_mdu_kind && w_mdu_busy;

    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_active) begin
            if (w_mdu_stall) begin
                w_cause = CAUSE_MDU;
            end else if (w_data_stall && i_id_early) begin
                w_cause = CAUSE_EARLY;
            end else if (w_data_stall) begin
                w_cause = CAUSE_DATA;
            end
        end
    end

    assign o_stall       = (w_cause != CAUSE_NONE);
    assign o_stall_cause = w_cause;
    assign w_fire        = w_active && !o_stall;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_dec[i] = (r_cnt[i] == '0) ? '0 : (r_cnt[i] - CNT_W'(1));
        end
    end

    assign w_issue_lat = (i_id_kind == OP_LOAD) ? L_LOAD : L_ALU;
    assign w_wr_en     = w_fire && i_id_wr && (i_id_rd != '0);
    // WAW: a younger short-latency write must not shorten an older long-latency one.
    assign w_load_val  = (w_dec[i_id_rd] > w_issue_lat) ? w_dec[i_id_rd] : w_issue_lat;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_en && (i_id_rd == IW'(i))) begin
                    r_cnt[i] <= w_load_val;
                end else begin
                    r_cnt[i] <= w_dec[i];
                end
            end
        end
    end

    assign w_mdu_start = w_fire && ((i_id_kind == OP_MUL) || (i_id_kind == OP_DIV));
    assign w_mdu_lat   = (i_id_kind == OP_DIV) ? L_DIV : L_MUL;

    mdu_busy_timer #(
        .CNT_W (CNT_W)
    ) u_mdu_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_mdu_start),
        .i_lat   (w_mdu_lat),
        .o_busy  (w_mdu_busy)
    );

    assign o_mdu_busy = w_mdu_busy;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (o_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign o_stall_count = r_stall_cnt;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational hazard detector.
- Holds a per-register countdown scoreboard of pending writes and a MDU busy timer.
- Raises an ID-stage stall when a source operand would not be forwardable in time, or when the HI/LO unit is busy.
- Sits beside the ID stage. Its stall freezes PC and IF/ID and injects a bubble into ID/EX. Also keeps a stall performance counter.

Parameters:
- NREG, 32, number of architectural registers; register 0 is never tracked.
- CNT_W, 4, width of each scoreboard countdown and of the MDU timer.
- LAT_ALU, 1, cycles from issue until an ALU result is forwardable to the next EX.
- LAT_LOAD, 2, same, for loads.
- LAT_MUL, 5, MDU multiply occupancy in cycles.
- LAT_DIV, 10, MDU divide occupancy in cycles.
- PERF_W, 32, stall counter width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- id_valid, in, 1, ID holds a real instruction.
- id_kill, in, 1, ID instruction is squashed this cycle (branch/exception flush); it is not recorded.
- id_rs, in, log2(NREG), source A index.
- id_rt, in, log2(NREG), source B index.
- id_use_rs, in, 1, source A is read.
- id_use_rt, in, 1, source B is read.
- id_early, in, 1, operands are needed in ID (Branch or JumpReg).
- id_wr, in, 1, instruction writes a GPR.
- id_rd, in, log2(NREG), destination index.
- id_kind, in, op_kind_t, ALU / LOAD / MUL / DIV / HILO_RD.
- stall, out, 1, hold ID this cycle (combinational from state and ID inputs).
- stall_cause, out, 2, 0 none, 1 data, 2 early-branch, 3 mdu.
- mdu_busy, out, 1, MDU timer nonzero.
- stall_count, out, PERF_W, saturating count of stalled cycles.

Behaviour:
- Reset state:
  - All scoreboard counters, the MDU timer and stall_count are 0.
  - Consequently stall=0, stall_cause=0, mdu_busy=0 while reset is asserted or just released.
  - Reset asserted mid-operation clears all pending state immediately; nothing is retained.
- Issue and decrement:
  - fire = id_valid & ~id_kill & ~stall.
  - Each clock, every nonzero counter decrements by 1.
  - On fire with id_wr & id_rd!=0: cnt[id_rd] <= max(cnt[id_rd]-1, LAT of id_kind). Kinds LOAD→LAT_LOAD, HILO_RD→LAT_ALU, others→LAT_ALU.
  - The load takes priority over the decrement for that entry.
- Data stall: some used source s has s!=0 and cnt[s] > (id_early ? 0 : 1).
  - ALU→dependent: no stall.
  - LOAD→dependent: 1 cycle.
  - ALU→branch/JR: 1 cycle.
  - LOAD→branch/JR: 2 cycles.
- Hazard check order: the check uses the pre-update counter values. An instruction whose rd equals its own rs does not stall on itself.
- MDU:
  - On fire with kind MUL or DIV: if the timer is 0, load it with LAT_MUL or LAT_DIV.
  - MDU stall: kind ∈ {MUL, DIV, HILO_RD} and timer != 0. The instruction waits; the timer decrements to 0 and then the instruction issues.
  - mdu_busy = timer != 0.
- stall_cause priority: mdu (3) > early-branch (2, data stall with id_early) > data (1).
- stall is forced 0 when id_valid=0 or id_kill=1.
- stall_count increments on every cycle with stall=1 and holds at all-ones.
- Widths: counters saturate at 0, never wrap. Parameters require LAT_DIV < 2^CNT_W; violating this is an elaboration error.

Decomposition:
- hazard_pkg holds:
  - op_kind_t enum (3 bits).
  - stall_cause_t.
  - Default latency localparams.
  - clog2 helper for index width.
- One sub-module, mdu_busy_timer, owns the MDU countdown. Interface: clk, reset, start, lat, busy.

Test Plan:
- Reset mid-stall:
  - Stimulus: LOAD to r5 fires, then assert reset the next cycle.
  - Required: cnt cleared; stall=0 and mdu_busy=0 in the same cycle; after release, a consumer of r5 issues with no stall.
- Load-use:
  - Stimulus: LOAD r8 fires at t; ADD reading r8 in ID at t+1.
  - Required: stall=1, cause=1 at t+1; stall=0 at t+2; stall_count=1.
- Branch after ALU and after LOAD:
  - ALU writes r3, then BEQ on r3 with id_early=1: exactly 1 stall cycle, cause=2.
  - Same sequence with a LOAD producer: exactly 2 stall cycles.
- r0 and kill:
  - LOAD to r0 followed by a reader of r0: no stall.
  - LOAD r9 with id_kill=1, then a reader of r9: no stall; cnt[9] stays 0.
- MDU:
  - DIV fires at t with LAT_DIV=10; mdu_busy=1 for t+1..t+10.
  - MFLO in ID stalls with cause=3 until the timer is 0, then issues.
  - stall_count advances by the stall cycles.
- WAW and saturation:
  - LOAD r4, then ALU r4 on the next cycle: cnt[4] = max(1,1) = 1.
  - Force stall_count to all-ones (PERF_W=4 build); it holds at 15 while stalled.
